// File: rtl/lighthouse_pkg.sv
// Shared thresholds, FSM state, sync-code and sweep-result types for the
// lighthouse pulse decoder.
package lighthouse_pkg;

  function automatic int b_ticks(input int clk_hz);
    return clk_hz / 96000;
  endfunction

  function automatic int s0_ticks(input int clk_hz);
    return (11 * b_ticks(clk_hz)) / 2;
  endfunction

  function automatic int sweep_max_ticks(input int clk_hz);
    return clk_hz / 20000;
  endfunction

  function automatic int pair_win_ticks(input int clk_hz);
    return clk_hz / 2000;
  endfunction

  function automatic int armed_timeout_ticks(input int clk_hz);
    return clk_hz / 120;
  endfunction

  function automatic int glitch_min_ticks(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_GROUP     = 2'd1,
    ST_ARMED     = 2'd2
  } state_t;

  typedef struct packed {
    logic skip;
    logic data;
    logic axis;
  } sync_code_t;

  // Slot and axis of a sweep; timestamp and width travel alongside at
  // their parameterised widths.
  typedef struct packed {
    logic lh;
    logic axis;
  } sweep_result_t;

endpackage

// File: rtl/lighthouse_pulse_meter.sv
// Envelope synchronizer, edge detect and pulse-width measurement.
// LIGHTHOUSE_DECODER_GLITCH_FILTER_EN drops pulses shorter than 1 us.
module lighthouse_pulse_meter
  import lighthouse_pkg::*;
#(
  parameter int CLK_HZ  = 48_000_000,
  parameter int TS_W    = 20,
  parameter int WIDTH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               env,
  input  logic [TS_W-1:0]    tick,
  output logic               pulse_stb,
  output logic [TS_W-1:0]    rise_time,
  output logic [WIDTH_W-1:0] width,
  output logic               busy
);

`ifdef LIGHTHOUSE_DECODER_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif
  localparam logic [WIDTH_W-1:0] GLITCH_MIN_W = WIDTH_W'(glitch_min_ticks(CLK_HZ));

  logic               sync_q1, sync_q2, env_prev;
  logic [1:0]         primed;
  logic               seen_low, in_pulse;
  logic [WIDTH_W-1:0] width_cnt;
  logic [TS_W-1:0]    rise_lat;
  logic               rise, fall, keep;

  // A rise only counts once a genuine low has been seen after reset, so a
  // pulse already in progress at reset release is never measured.
  assign rise = sync_q2 & ~env_prev & seen_low;
  assign fall = ~sync_q2 & env_prev & in_pulse;
  assign keep = !GLITCH_EN || (width_cnt >= GLITCH_MIN_W);
  assign busy = in_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      env_prev  <= 1'b0;
      primed    <= 2'b00;
      seen_low  <= 1'b0;
      in_pulse  <= 1'b0;
      width_cnt <= '0;
      rise_lat  <= '0;
      pulse_stb <= 1'b0;
      rise_time <= '0;
      width     <= '0;
    end else begin
      sync_q1   <= env;
      sync_q2   <= sync_q1;
      env_prev  <= sync_q2;
      primed    <= {primed[0], 1'b1};
      pulse_stb <= 1'b0;
      if (primed[1] && !sync_q2) seen_low <= 1'b1;
      if (rise) begin
        width_cnt <= WIDTH_W'(1);
        rise_lat  <= tick;
        in_pulse  <= 1'b1;
      end else if (in_pulse && sync_q2 && width_cnt != '1) begin
        width_cnt <= width_cnt + WIDTH_W'(1);
      end
      if (fall) begin
        in_pulse  <= 1'b0;
        pulse_stb <= keep;
        width     <= width_cnt;
        rise_time <= rise_lat;
      end
    end
  end

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Classifies TS4231 envelope pulses into syncs and sweeps, tracks sync groups
// and emits timestamped sweep results. Glitch filter: LIGHTHOUSE_DECODER_GLITCH_FILTER_EN.
//
// state        | meaning
// WAIT_SYNC    | idle, waiting for a slot-0 sync
// GROUP        | inside pair window, collecting slot 0/1 syncs
// ARMED        | sweeper known, waiting for its sweep pulse
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int CLK_HZ  = 48_000_000,
  parameter int TS_W    = 20,
  parameter int WIDTH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               env_i,
  input  logic               watch_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic               res_lh_o,
  output logic               res_axis_o,
  output logic [TS_W-1:0]    res_ts_o,
  output logic [WIDTH_W-1:0] res_width_o,
  output logic               sync_stb_o,
  output logic               sync_lh_o,
  output logic               sync_data_o,
  output logic               overrun_o
);

  localparam int B_T  = b_ticks(CLK_HZ);
  localparam int S0_T = s0_ticks(CLK_HZ);
  localparam logic [WIDTH_W-1:0] SWEEP_MAX_W = WIDTH_W'(sweep_max_ticks(CLK_HZ));
  localparam logic [WIDTH_W-1:0] S0_W        = WIDTH_W'(S0_T);
  localparam logic [WIDTH_W-1:0] SYNC_END_W  = WIDTH_W'(S0_T + 8 * B_T);
  localparam logic [TS_W-1:0]    PAIR_WIN_T  = TS_W'(pair_win_ticks(CLK_HZ));
  localparam logic [TS_W-1:0]    TIMEOUT_T   = TS_W'(armed_timeout_ticks(CLK_HZ));

  logic [TS_W-1:0]    tick;
  logic               pulse_stb, busy;
  logic [TS_W-1:0]    rise_time;
  logic [WIDTH_W-1:0] width;

  lighthouse_pulse_meter #(
    .CLK_HZ (CLK_HZ),
    .TS_W   (TS_W),
    .WIDTH_W(WIDTH_W)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .env      (env_i),
    .tick     (tick),
    .pulse_stb(pulse_stb),
    .rise_time(rise_time),
    .width    (width),
    .busy     (busy)
  );

  state_t        state, state_n;
  logic [TS_W-1:0] t0, grp_cnt, sync_rel;
  logic          slot1_seen, sw_valid;
  sweep_result_t sweeper;
  sync_code_t    code;
  logic [2:0]    code_n;
  logic          is_sweep, is_sync, slot1_ok;
  logic          sync_acc, slot0, slot1, res_load;

  // Code n = (width - S0) / B without a divider: count the bin edges passed.
  always_comb begin
    code_n = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (width >= WIDTH_W'(S0_T + k * B_T)) code_n = 3'(k);
    end
  end

  assign code     = sync_code_t'(code_n);
  assign is_sweep = pulse_stb && (width < SWEEP_MAX_W);
  assign is_sync  = pulse_stb && (width >= S0_W) && (width < SYNC_END_W);
  assign sync_rel = rise_time - t0;
  assign slot1_ok = !slot1_seen && (sync_rel < PAIR_WIN_T);

  always_comb begin
    state_n  = state;
    sync_acc = 1'b0;
    slot0    = 1'b0;
    slot1    = 1'b0;
    res_load = 1'b0;
    if (!watch_i) begin
      state_n = ST_WAIT_SYNC;
    end else begin
      case (state)
        ST_WAIT_SYNC: begin
          if (is_sync) begin
            sync_acc = 1'b1;
            slot0    = 1'b1;
            state_n  = ST_GROUP;
          end
        end
        ST_GROUP: begin
          if (is_sync) begin
            sync_acc = 1'b1;
            if (slot1_ok) slot1 = 1'b1;
            else          slot0 = 1'b1;
          end else if (grp_cnt >= PAIR_WIN_T && !busy) begin
            // A slot-1 sync still in flight is allowed to finish first.
            state_n = sw_valid ? ST_ARMED : ST_WAIT_SYNC;
          end
        end
        ST_ARMED: begin
          if (is_sync) begin
            sync_acc = 1'b1;
            slot0    = 1'b1;
            state_n  = ST_GROUP;
          end else if (is_sweep) begin
            res_load = 1'b1;
            state_n  = ST_WAIT_SYNC;
          end else if (grp_cnt >= TIMEOUT_T) begin
            state_n = ST_WAIT_SYNC;
          end
        end
        default: state_n = ST_WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT_SYNC;
      tick        <= '0;
      t0          <= '0;
      grp_cnt     <= '0;
      slot1_seen  <= 1'b0;
      sw_valid    <= 1'b0;
      sweeper     <= '0;
      sync_stb_o  <= 1'b0;
      sync_lh_o   <= 1'b0;
      sync_data_o <= 1'b0;
      res_valid_o <= 1'b0;
      res_lh_o    <= 1'b0;
      res_axis_o  <= 1'b0;
      res_ts_o    <= '0;
      res_width_o <= '0;
      overrun_o   <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick + TS_W'(1);
      sync_stb_o <= sync_acc;
      overrun_o  <= 1'b0;
      if (sync_acc) begin
        sync_lh_o   <= slot1;
        sync_data_o <= code.data;
      end
      // The group counter is rebased so that it reads ticks since slot-0 rise.
      if (slot0) begin
        t0           <= rise_time;
        grp_cnt      <= tick - rise_time + TS_W'(1);
        slot1_seen   <= 1'b0;
        sw_valid     <= !code.skip;
        sweeper.lh   <= 1'b0;
        sweeper.axis <= code.axis;
      end else begin
        if (grp_cnt != '1) grp_cnt <= grp_cnt + TS_W'(1);
        if (slot1) begin
          slot1_seen <= 1'b1;
          if (!sw_valid && !code.skip) begin
            sw_valid     <= 1'b1;
            sweeper.lh   <= 1'b1;
            sweeper.axis <= code.axis;
          end
        end
      end
      if (res_load) begin
        if (!res_valid_o || res_ready_i) begin
          res_valid_o <= 1'b1;
          res_lh_o    <= sweeper.lh;
          res_axis_o  <= sweeper.axis;
          res_ts_o    <= sync_rel + TS_W'(width >> 1);
          res_width_o <= width;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (res_ready_i) begin
        res_valid_o <= 1'b0;
      end
    end
  end

endmodule
